rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Write-back arbiter for the register file and PSR. Three requesters compete for the single register-file write port: the ALU result, load data from memory, and the base-register update from LDR/STR with writeback. The block grants one requester per cycle using round-robin with a starvation override. It registers the chosen write onto the port and drives the PSR load for ALU requests that carry the S bit.

## Interface
Parameters:
- DATA_W, 32, register data width
- ADDR_W, 4, register index width (R0–R15)
- MAX_WAIT, 4, consecutive stalled cycles before a requester gets forced priority (range 1–15)

Ports:
- Clk  in  1  single clock, rising edge
- Rst  in  1  reset; asynchronous, active-high
- alu_valid  in  1  ALU request present
- alu_we  in  1  1 = write alu_addr/alu_data; 0 = flag-only request (CMP/TST)
- alu_s  in  1  update PSR with alu_nzcv
- alu_addr  in  ADDR_W  destination register
- alu_data  in  DATA_W  result
- alu_nzcv  in  4  {N,Z,C,V}
- alu_ready  out  1  grant; combinational
- ld_valid, ld_addr, ld_data  in  1/ADDR_W/DATA_W  load write-back request
- ld_ready  out  1  grant; combinational
- wb_valid, wb_addr, wb_data  in  1/ADDR_W/DATA_W  base-register update request
- wb_ready  out  1  grant; combinational
- rf_we  out  1  register-file write enable
- rf_wa  out  ADDR_W  write address
- rf_wd  out  DATA_W  write data
- psr_ld  out  1  PSR load strobe
- N, Z, C, V  out  1 each  flag values presented to the PSR
- pc_wr  out  1  pulses with rf_we when rf_wa == 15 (pipeline flush)

## Operation
- Handshake is valid/ready. Once a requester asserts valid, it holds valid and the payload stable until ready=1. The transfer occurs on the rising edge where valid && ready.
- Exactly one ready is high per cycle, and only if at least one valid is high. Requester indices: ALU=0, LD=1, WB=2.
- Round-robin pointer rr (2 bits, values 0–2) names the highest-priority requester. Search order is rr, rr+1, rr+2 (mod 3). After a grant to index i, rr ← (i+1) mod 3. rr is unchanged if nothing is granted.
- Each requester has a wait counter:
  - Increments each cycle valid && !ready, saturating at MAX_WAIT.
  - Clears on a grant or when valid is low.
  - Any requester with counter == MAX_WAIT overrides round-robin. If several qualify, the lowest index wins.
- On a grant, the next-cycle outputs are:
  - ALU: rf_we=alu_we, rf_wa=alu_addr, rf_wd=alu_data, psr_ld=alu_s, {N,Z,C,V}=alu_nzcv when alu_s.
  - LD / WB: rf_we=1 with its addr/data, psr_ld=0.
- N/Z/C/V hold their last loaded value when psr_ld=0.
- pc_wr = rf_we && rf_wa == 15.
- With no grant, the next cycle has rf_we=0, psr_ld=0, pc_wr=0. rf_wa and rf_wd hold.
- Same destination from two requesters in one cycle: the winner writes first and the loser writes later, so the loser's value persists. Ordering between requesters is the issuing stage's responsibility.
- Reset behaviour:
  - Rst=1 at any time immediately clears rf_we, rf_wa, rf_wd, psr_ld, N, Z, C, V, pc_wr, rr and all wait counters to 0. All ready outputs are 0 while Rst=1.
  - In-flight requests are dropped and must be re-presented after reset.

## Timing
- Grant latency is 0 cycles: ready is combinational from valid, rr and the wait counters.
- Write latency is 1 cycle: the port outputs are registered and valid in the cycle after the handshake edge.
- Sustained throughput is one write per cycle.
- No combinational path from any payload input to any output.

## Structure
- Shared package holds:
  - Requester index constants REQ_ALU=0, REQ_LD=1, REQ_WB=2.
  - PC_ADDR=4'd15.
  - Flag-vector bit positions N=3, Z=2, C=1, V=0.
- Sub-module rr_arb3 contains the rr pointer, wait counters and grant logic. Outputs: one-hot grant[2:0] and any_grant.
- The top level contains the payload mux and the output registers.

## Test plan
- Reset, then ld_valid with ld_addr=3, ld_data=0xDEADBEEF → ld_ready=1 the same cycle. Next cycle rf_we=1, rf_wa=3, rf_wd=0xDEADBEEF, psr_ld=0.
- All three valid continuously from reset (rr=0) → grants ALU, LD, WB, ALU… on consecutive cycles. Exactly one ready per cycle.
- alu_valid, alu_we=0, alu_s=1, nzcv=4'b0110 → next cycle rf_we=0, psr_ld=1, Z=1, C=1, N=0, V=0. Flags hold afterwards.
- wb_valid with wb_addr=15 → next cycle rf_we=1, pc_wr=1 for exactly one cycle.
- MAX_WAIT=2, with ALU and LD valid every cycle and WB held off by round-robin ordering → WB is granted no later than its third stalled cycle via the override.
- Assert Rst mid-stream while rf_we=1 → all outputs are 0 immediately, not waiting for Clk. After release, rr=0 and the first grant goes to the lowest valid index starting from ALU.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants for the register-file write-back arbiter
package rf_wb_arbiter_pkg;

   localparam int REQ_ALU = 0;
   localparam int REQ_LD  = 1;
   localparam int REQ_WB  = 2;
   localparam int NUM_REQ = 3;

   localparam logic [3:0] PC_ADDR = 4'd15;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   function automatic logic [1:0] rr_next(input logic [1:0] idx);
      return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
   endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr_arb3.sv
// rtl/rf_wb_arbiter_rr_arb3.sv - three-way round-robin arbiter with starvation override
module rr_arb3
   import rf_wb_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] valid,
   output logic [NUM_REQ-1:0] grant,
   output logic               any_grant
);

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   logic [1:0]         rr_q, rr_d;
   logic [3:0]         wait_q [NUM_REQ];
   logic [3:0]         wait_d [NUM_REQ];
   logic [NUM_REQ-1:0] gnt;
   logic [1:0]         idx;

   // A starved requester wins outright; otherwise search from rr upward.
   always_comb begin
      gnt = '0;
      idx = rr_q;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt == '0 && valid[i] && wait_q[i] == WAIT_MAX) gnt[i] = 1'b1;
      end
      for (int k = 0; k < NUM_REQ; k++) begin
         if (gnt == '0 && valid[idx]) gnt[idx] = 1'b1;
         idx = rr_next(idx);
      end
      if (rst) gnt = '0;
   end

   assign grant     = gnt;
   assign any_grant = |gnt;

   always_comb begin
      rr_d = rr_q;
      if (gnt[REQ_ALU])     rr_d = 2'(REQ_LD);
      else if (gnt[REQ_LD]) rr_d = 2'(REQ_WB);
      else if (gnt[REQ_WB]) rr_d = 2'(REQ_ALU);
      for (int i = 0; i < NUM_REQ; i++) begin
         if (valid[i] && !gnt[i]) wait_d[i] = (wait_q[i] == WAIT_MAX) ? WAIT_MAX : wait_q[i] + 4'd1;
         else                     wait_d[i] = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_q <= '0;
         for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
      end else begin
         rr_q <= rr_d;
         for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= wait_d[i];
      end
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file / PSR write-back arbiter top level
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 4,
   parameter int MAX_WAIT = 4
)
(
   input  logic              Clk,
   input  logic              Rst,
   input  logic              alu_valid,
   input  logic              alu_we,
   input  logic              alu_s,
   input  logic [ADDR_W-1:0] alu_addr,
   input  logic [DATA_W-1:0] alu_data,
   input  logic [3:0]        alu_nzcv,
   output logic              alu_ready,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   input  logic [DATA_W-1:0] wb_data,
   output logic              wb_ready,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_wa,
   output logic [DATA_W-1:0] rf_wd,
   output logic              psr_ld,
   output logic              N,
   output logic              Z,
   output logic              C,
   output logic              V,
   output logic              pc_wr
);

   logic [NUM_REQ-1:0] valid, grant;
   logic               any_grant;

   logic              rf_we_q, rf_we_d;
   logic [ADDR_W-1:0] rf_wa_q, rf_wa_d;
   logic [DATA_W-1:0] rf_wd_q, rf_wd_d;
   logic              psr_ld_q, psr_ld_d;
   logic [3:0]        nzcv_q, nzcv_d;
   logic              pc_wr_q, pc_wr_d;

   assign valid = {wb_valid, ld_valid, alu_valid};

   rr_arb3 #(.MAX_WAIT(MAX_WAIT)) u_arb (
      .clk       (Clk),
      .rst       (Rst),
      .valid     (valid),
      .grant     (grant),
      .any_grant (any_grant)
   );

   assign alu_ready = grant[REQ_ALU];
   assign ld_ready  = grant[REQ_LD];
   assign wb_ready  = grant[REQ_WB];

   // Address and data hold across idle cycles; flags hold until the next S-bit ALU write.
   always_comb begin
      rf_we_d  = 1'b0;
      rf_wa_d  = rf_wa_q;
      rf_wd_d  = rf_wd_q;
      psr_ld_d = 1'b0;
      nzcv_d   = nzcv_q;
      if (any_grant) begin
         if (grant[REQ_ALU]) begin
            rf_we_d  = alu_we;
            rf_wa_d  = alu_addr;
            rf_wd_d  = alu_data;
            psr_ld_d = alu_s;
            if (alu_s) nzcv_d = alu_nzcv;
         end else if (grant[REQ_LD]) begin
            rf_we_d = 1'b1;
            rf_wa_d = ld_addr;
            rf_wd_d = ld_data;
         end else begin
            rf_we_d = 1'b1;
            rf_wa_d = wb_addr;
            rf_wd_d = wb_data;
         end
      end
      pc_wr_d = rf_we_d && (rf_wa_d == ADDR_W'(PC_ADDR));
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         rf_we_q  <= 1'b0;
         rf_wa_q  <= '0;
         rf_wd_q  <= '0;
         psr_ld_q <= 1'b0;
         nzcv_q   <= '0;
         pc_wr_q  <= 1'b0;
      end else begin
         rf_we_q  <= rf_we_d;
         rf_wa_q  <= rf_wa_d;
         rf_wd_q  <= rf_wd_d;
         psr_ld_q <= psr_ld_d;
         nzcv_q   <= nzcv_d;
         pc_wr_q  <= pc_wr_d;
      end
   end

   assign rf_we  = rf_we_q;
   assign rf_wa  = rf_wa_q;
   assign rf_wd  = rf_wd_q;
   assign psr_ld = psr_ld_q;
   assign N      = nzcv_q[FLAG_N];
   assign Z      = nzcv_q[FLAG_Z];
   assign C      = nzcv_q[FLAG_C];
   assign V      = nzcv_q[FLAG_V];
   assign pc_wr  = pc_wr_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - scoreboard bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int MW = 2;

   typedef struct packed {
      logic          we;
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
      logic          psr;
      logic [3:0]    f;
      logic          pc;
   } exp_t;

   logic Clk, Rst;
   logic alu_valid, alu_we, alu_s;
   logic [AW-1:0] alu_addr, ld_addr, wb_addr;
   logic [DW-1:0] alu_data, ld_data, wb_data;
   logic [3:0] alu_nzcv;
   logic ld_valid, wb_valid;
   logic alu_ready, ld_ready, wb_ready, rf_we, psr_ld, N, Z, C, V, pc_wr;
   logic [AW-1:0] rf_wa;
   logic [DW-1:0] rf_wd;
   logic d1_alu_ready, d1_ld_ready, d1_wb_ready, d1_rf_we, d1_psr_ld, d1_N, d1_Z, d1_C, d1_V, d1_pc_wr;
   logic [AW-1:0] d1_rf_wa;
   logic [DW-1:0] d1_rf_wd;

   logic [42:0] obs_out;
   logic [2:0]  obs_rdy, d1_rdy;
   assign obs_out = {rf_we, rf_wa, rf_wd, psr_ld, N, Z, C, V, pc_wr};
   assign obs_rdy = {wb_ready, ld_ready, alu_ready};
   assign d1_rdy  = {d1_wb_ready, d1_ld_ready, d1_alu_ready};

   int n_pass = 0;
   int n_total = 0;

   int            m_rr;
   int            m_w [3];
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;
   logic [3:0]    m_f;
   exp_t          sb [$];

   rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(MW)) u_dut (
      .Clk(Clk), .Rst(Rst),
      .alu_valid(alu_valid), .alu_we(alu_we), .alu_s(alu_s), .alu_addr(alu_addr),
      .alu_data(alu_data), .alu_nzcv(alu_nzcv), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .psr_ld(psr_ld),
      .N(N), .Z(Z), .C(C), .V(V), .pc_wr(pc_wr)
   );

   rf_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .MAX_WAIT(1)) u_dut1 (
      .Clk(Clk), .Rst(Rst),
      .alu_valid(alu_valid), .alu_we(alu_we), .alu_s(alu_s), .alu_addr(alu_addr),
      .alu_data(alu_data), .alu_nzcv(alu_nzcv), .alu_ready(d1_alu_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(d1_ld_ready),
      .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(d1_wb_ready),
      .rf_we(d1_rf_we), .rf_wa(d1_rf_wa), .rf_wd(d1_rf_wd), .psr_ld(d1_psr_ld),
      .N(d1_N), .Z(d1_Z), .C(d1_C), .V(d1_V), .pc_wr(d1_pc_wr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic [2:0] model_grant();
      logic [2:0] v, g;
      int idx;
      v = {wb_valid, ld_valid, alu_valid};
      g = '0;
      if (Rst) return 3'b000;
      for (int i = 0; i < 3; i++)
         if (g == 3'b000 && v[i] && m_w[i] == MW) g[i] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         idx = (m_rr + k) % 3;
         if (g == 3'b000 && v[idx]) g[idx] = 1'b1;
      end
      return g;
   endfunction

   task automatic model_reset();
      m_rr = 0;
      for (int i = 0; i < 3; i++) m_w[i] = 0;
      m_wa = '0;
      m_wd = '0;
      m_f  = '0;
      sb.delete();
   endtask

   task automatic clear_inputs();
      alu_valid = 0; alu_we = 0; alu_s = 0; alu_addr = '0; alu_data = '0; alu_nzcv = '0;
      ld_valid = 0; ld_addr = '0; ld_data = '0;
      wb_valid = 0; wb_addr = '0; wb_data = '0;
   endtask

   task automatic clk_step(input logic [2:0] g);
      exp_t e;
      logic [2:0] v;
      v = {wb_valid, ld_valid, alu_valid};
      e.we = 1'b0;
      e.psr = 1'b0;
      if (g[0]) begin
         e.we = alu_we; m_wa = alu_addr; m_wd = alu_data; e.psr = alu_s;
         if (alu_s) m_f = alu_nzcv;
      end else if (g[1]) begin
         e.we = 1'b1; m_wa = ld_addr; m_wd = ld_data;
      end else if (g[2]) begin
         e.we = 1'b1; m_wa = wb_addr; m_wd = wb_data;
      end
      e.wa = m_wa;
      e.wd = m_wd;
      e.f  = m_f;
      e.pc = e.we && (m_wa == 4'd15);
      sb.push_back(e);
      for (int i = 0; i < 3; i++)
         m_w[i] = (v[i] && !g[i]) ? ((m_w[i] < MW) ? m_w[i] + 1 : MW) : 0;
      if (g[0]) m_rr = 1;
      else if (g[1]) m_rr = 2;
      else if (g[2]) m_rr = 0;
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge Clk);
      #1;
      Rst = 1'b1;
      clear_inputs();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      Rst = 1'b1;
      clear_inputs();
      alu_valid = 1; ld_valid = 1; wb_valid = 1;
      #3;
      n_total++;
      if (obs_rdy !== 3'b000) $display("FAIL reset_ready: got %b want 000", obs_rdy); else n_pass++;
      n_total++;
      if (obs_out !== 43'd0) $display("FAIL reset_outputs: got %h want 0", obs_out); else n_pass++;
      n_total++;
      if (d1_rdy !== 3'b000) $display("FAIL reset_ready_mw1: got %b want 000", d1_rdy); else n_pass++;
      clear_inputs();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      model_reset();
   endtask

   task automatic test_load();
      logic [2:0] g;
      exp_t e;
      ld_valid = 1; ld_addr = 4'd3; ld_data = 32'hDEAD_BEEF;
      #1;
      g = model_grant();
      n_total++;
      if (obs_rdy !== 3'b010) $display("FAIL load_ready: got %b want 010", obs_rdy); else n_pass++;
      clk_step(g);
      ld_valid = 0;
      e = sb.pop_front();
      n_total++;
      if (obs_out !== e) $display("FAIL load_out: got %h want %h", obs_out, e); else n_pass++;
      n_total++;
      if ({rf_we, rf_wa, rf_wd, psr_ld} !== {1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0})
         $display("FAIL load_port: got we=%b wa=%0d wd=%h psr=%b want we=1 wa=3 wd=deadbeef psr=0", rf_we, rf_wa, rf_wd, psr_ld);
      else n_pass++;
   endtask

   task automatic test_round_robin();
      logic [2:0] g;
      exp_t e;
      do_reset();
      alu_valid = 1; alu_we = 1; alu_s = 0; alu_addr = 4'd1; alu_data = 32'h1111_0001;
      ld_valid = 1; ld_addr = 4'd2; ld_data = 32'h2222_0002;
      wb_valid = 1; wb_addr = 4'd4; wb_data = 32'h4444_0004;
      for (int c = 0; c < 6; c++) begin
         #1;
         g = model_grant();
         n_total++;
         if (obs_rdy !== (3'b001 << (c % 3)) || obs_rdy !== g)
            $display("FAIL rr_ready c%0d: got %b want %b", c, obs_rdy, 3'b001 << (c % 3));
         else n_pass++;
         n_total++;
         if (d1_rdy !== (3'b001 << (c % 2)))
            $display("FAIL override_mw1 c%0d: got %b want %b", c, d1_rdy, 3'b001 << (c % 2));
         else n_pass++;
         clk_step(g);
         e = sb.pop_front();
         n_total++;
         if (obs_out !== e) $display("FAIL rr_out c%0d: got %h want %h", c, obs_out, e); else n_pass++;
      end
      clear_inputs();
   endtask

   task automatic test_flags();
      logic [2:0] g;
      exp_t e;
      alu_valid = 1; alu_we = 0; alu_s = 1; alu_nzcv = 4'b0110; alu_addr = 4'd7; alu_data = 32'h55;
      #1;
      g = model_grant();
      n_total++;
      if (obs_rdy !== 3'b001) $display("FAIL flags_ready: got %b want 001", obs_rdy); else n_pass++;
      clk_step(g);
      alu_valid = 0;
      e = sb.pop_front();
      n_total++;
      if (obs_out !== e) $display("FAIL flags_out: got %h want %h", obs_out, e); else n_pass++;
      n_total++;
      if ({rf_we, psr_ld, N, Z, C, V} !== 6'b01_0110)
         $display("FAIL flags_load: got %b want 010110", {rf_we, psr_ld, N, Z, C, V});
      else n_pass++;
      for (int c = 0; c < 2; c++) begin
         #1;
         g = model_grant();
         n_total++;
         if (obs_rdy !== 3'b000) $display("FAIL idle_ready c%0d: got %b want 000", c, obs_rdy); else n_pass++;
         clk_step(g);
         e = sb.pop_front();
         n_total++;
         if (obs_out !== e || {rf_we, psr_ld, N, Z, C, V} !== 6'b00_0110)
            $display("FAIL flags_hold c%0d: got %h want %h", c, obs_out, e);
         else n_pass++;
      end
   endtask

   task automatic test_pc_write();
      logic [2:0] g;
      exp_t e;
      wb_valid = 1; wb_addr = 4'd15; wb_data = 32'h0000_1000;
      #1;
      g = model_grant();
      clk_step(g);
      wb_valid = 0;
      e = sb.pop_front();
      n_total++;
      if ({rf_we, pc_wr, rf_wa} !== {1'b1, 1'b1, 4'd15} || obs_out !== e)
         $display("FAIL pc_wr_pulse: got we=%b pc=%b wa=%0d want we=1 pc=1 wa=15", rf_we, pc_wr, rf_wa);
      else n_pass++;
      #1;
      g = model_grant();
      clk_step(g);
      e = sb.pop_front();
      n_total++;
      if (pc_wr !== 1'b0 || obs_out !== e) $display("FAIL pc_wr_clear: got pc=%b want 0", pc_wr); else n_pass++;
   endtask

   task automatic test_starvation();
      logic [2:0] g;
      exp_t e;
      int stalled;
      logic got;
      do_reset();
      alu_valid = 1; alu_we = 1; alu_addr = 4'd5; alu_data = 32'hA;
      ld_valid = 1; ld_addr = 4'd6; ld_data = 32'hB;
      wb_valid = 1; wb_addr = 4'd8; wb_data = 32'hC;
      stalled = 0;
      got = 1'b0;
      for (int c = 0; c < 5 && !got; c++) begin
         #1;
         g = model_grant();
         n_total++;
         if (obs_rdy !== g) $display("FAIL starve_ready c%0d: got %b want %b", c, obs_rdy, g); else n_pass++;
         if (wb_ready === 1'b1) got = 1'b1;
         else stalled++;
         clk_step(g);
         e = sb.pop_front();
         n_total++;
         if (obs_out !== e) $display("FAIL starve_out c%0d: got %h want %h", c, obs_out, e); else n_pass++;
      end
      n_total++;
      if (!got || stalled > MW) $display("FAIL wb_starvation: granted=%b stalled=%0d want granted=1 stalled<=%0d", got, stalled, MW);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [2:0] g;
      exp_t e;
      #1;
      g = model_grant();
      clk_step(g);
      e = sb.pop_front();
      n_total++;
      if (rf_we !== 1'b1 || obs_out !== e) $display("FAIL pre_reset_write: got %h want %h", obs_out, e); else n_pass++;
      Rst = 1'b1;
      #1;
      n_total++;
      if ({obs_out, obs_rdy} !== 46'd0) $display("FAIL async_reset: got out=%h rdy=%b want 0", obs_out, obs_rdy); else n_pass++;
      model_reset();
      @(posedge Clk);
      #1;
      alu_valid = 0;
      Rst = 1'b0;
      #1;
      g = model_grant();
      n_total++;
      if (obs_rdy !== 3'b010) $display("FAIL post_reset_grant: got %b want 010", obs_rdy); else n_pass++;
      clk_step(g);
      e = sb.pop_front();
      n_total++;
      if (obs_out !== e) $display("FAIL post_reset_out: got %h want %h", obs_out, e); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_random();
      logic [2:0] g;
      exp_t e;
      for (int c = 0; c < 300; c++) begin
         if (!alu_valid && $urandom_range(1, 0) == 1) begin
            alu_valid = 1; alu_we = 1'($urandom_range(1, 0)); alu_s = 1'($urandom_range(1, 0));
            alu_addr = 4'($urandom_range(15, 0)); alu_data = $urandom; alu_nzcv = 4'($urandom_range(15, 0));
         end
         if (!ld_valid && $urandom_range(1, 0) == 1) begin
            ld_valid = 1; ld_addr = 4'($urandom_range(15, 0)); ld_data = $urandom;
         end
         if (!wb_valid && $urandom_range(1, 0) == 1) begin
            wb_valid = 1; wb_addr = 4'($urandom_range(15, 0)); wb_data = $urandom;
         end
         #1;
         g = model_grant();
         n_total++;
         if (obs_rdy !== g) $display("FAIL rand_ready c%0d: got %b want %b", c, obs_rdy, g); else n_pass++;
         clk_step(g);
         e = sb.pop_front();
         n_total++;
         if (obs_out !== e) $display("FAIL rand_out c%0d: got %h want %h", c, obs_out, e); else n_pass++;
         if (g[0]) alu_valid = 0;
         if (g[1]) ld_valid = 0;
         if (g[2]) wb_valid = 0;
      end
      clear_inputs();
   endtask

   initial begin
      test_reset();
      test_load();
      test_round_robin();
      test_flags();
      test_pc_write();
      test_starvation();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
